// File: rtl/fir_out_stage.sv
// FIR output stage: arithmetic scaling, saturation to the output width, and a
// 2-entry skid FIFO driving an AXI-Stream master, with frame and clip counters.
module fir_out_stage #(
  parameter int unsigned C_S00_AXIS_TDATA_WIDTH = 32,
  parameter int unsigned C_M00_AXIS_TDATA_WIDTH = 16,
  parameter int unsigned SHIFT                  = 8
) (
  input  logic                              clk,
  input  logic                              rst_in,
  input  logic [C_S00_AXIS_TDATA_WIDTH-1:0] data_in,
  input  logic                              valid_in,
  input  logic                              last_in,
  output logic                              ready_out,
  output logic [C_M00_AXIS_TDATA_WIDTH-1:0] m00_axis_tdata,
  output logic                              m00_axis_tvalid,
  output logic                              m00_axis_tlast,
  input  logic                              m00_axis_tready,
  output logic [15:0]                       frame_count_out,
  output logic [15:0]                       sat_count_out
);

  localparam int unsigned W_IN  = C_S00_AXIS_TDATA_WIDTH;
  localparam int unsigned W_OUT = C_M00_AXIS_TDATA_WIDTH;
  localparam int unsigned CNT_W = 16;

  localparam logic signed [W_IN-1:0] SAT_MAX =
    {{(W_IN - W_OUT + 1){1'b0}}, {(W_OUT - 1){1'b1}}};
  localparam logic signed [W_IN-1:0] SAT_MIN =
    {{(W_IN - W_OUT + 1){1'b1}}, {(W_OUT - 1){1'b0}}};

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t state, state_next;

  logic [W_OUT-1:0] head_data, tail_data;
  logic             head_last, tail_last;
  logic [CNT_W-1:0] frame_count, sat_count;

  logic signed [W_IN-1:0] shifted;
  logic                   clip_hi, clip_lo, clipped;
  logic [W_OUT-1:0]       sat_val;
  logic                   push, pop;
  logic                   load_head_new, load_tail_new, shift_tail;

  // Scale and clip at push time so the FIFO only ever holds final samples.
  assign shifted = $signed(data_in) >>> SHIFT;
  assign clip_hi = shifted > SAT_MAX;
  assign clip_lo = shifted < SAT_MIN;
  assign clipped = clip_hi | clip_lo;
  assign sat_val = clip_hi ? SAT_MAX[W_OUT-1:0] :
                   clip_lo ? SAT_MIN[W_OUT-1:0] : shifted[W_OUT-1:0];

  assign ready_out       = (state != FULL) && !rst_in;
  assign m00_axis_tvalid = (state != EMPTY);
  assign m00_axis_tdata  = head_data;
  assign m00_axis_tlast  = head_last;
  assign frame_count_out = frame_count;
  assign sat_count_out   = sat_count;

  assign push = valid_in && ready_out;
  assign pop  = m00_axis_tvalid && m00_axis_tready;

  always_ff @(posedge clk) begin
    if (rst_in) state <= EMPTY;
    else        state <= state_next;
  end

  always_comb begin
    state_next    = state;
    load_head_new = 1'b0;
    load_tail_new = 1'b0;
    shift_tail    = 1'b0;
    case (state)
      EMPTY: begin
        if (push) begin
          state_next    = ONE;
          load_head_new = 1'b1;
        end
      end
      ONE: begin
        if (push && pop) begin
          load_head_new = 1'b1;
        end else if (push) begin
          state_next    = FULL;
          load_tail_new = 1'b1;
        end else if (pop) begin
          state_next = EMPTY;
        end
      end
      FULL: begin
        if (pop) begin
          state_next = ONE;
          shift_tail = 1'b1;
        end
      end
      default: state_next = EMPTY;
    endcase
  end

  // Head is always the oldest entry; tail only fills when head is occupied.
  always_ff @(posedge clk) begin
    if (rst_in) begin
      head_data <= '0;
      head_last <= 1'b0;
      tail_data <= '0;
      tail_last <= 1'b0;
    end else begin
      if (load_head_new) begin
        head_data <= sat_val;
        head_last <= last_in;
      end else if (shift_tail) begin
        head_data <= tail_data;
        head_last <= tail_last;
      end
      if (load_tail_new) begin
        tail_data <= sat_val;
        tail_last <= last_in;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst_in) begin
      frame_count <= '0;
      sat_count   <= '0;
    end else begin
      if (pop && head_last) frame_count <= frame_count + CNT_W'(1);
      if (push && clipped && (sat_count != {CNT_W{1'b1}}))
        sat_count <= sat_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_fir_out_stage.sv
// Self-checking bench for fir_out_stage: directed scenarios plus random traffic
// against a queue-based reference model of the scaled, saturated stream.
module tb_fir_out_stage;

  logic        clk = 1'b0;
  logic        rst_in;
  logic [31:0] data_in;
  logic        valid_in, last_in, ready_out;
  logic [15:0] m00_axis_tdata;
  logic        m00_axis_tvalid, m00_axis_tlast, m00_axis_tready;
  logic [15:0] frame_count_out, sat_count_out;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [15:0] data;
    logic        last;
  } ent_t;

  ent_t        mq[$];
  logic [15:0] m_frames = '0;
  logic [15:0] m_sat    = '0;

  fir_out_stage dut (
    .clk             (clk),
    .rst_in          (rst_in),
    .data_in         (data_in),
    .valid_in        (valid_in),
    .last_in         (last_in),
    .ready_out       (ready_out),
    .m00_axis_tdata  (m00_axis_tdata),
    .m00_axis_tvalid (m00_axis_tvalid),
    .m00_axis_tlast  (m00_axis_tlast),
    .m00_axis_tready (m00_axis_tready),
    .frame_count_out (frame_count_out),
    .sat_count_out   (sat_count_out)
  );

  always #5 clk = ~clk;

  // Floor-divide by 256 and clamp to int16; bit 16 flags a clip.
  function automatic logic [16:0] model_scale(input logic [31:0] d);
    longint r;
    logic [15:0] v;
    r = longint'($signed(d));
    r = r >>> 8;
    if (r > 32767)       return {1'b1, 16'h7FFF};
    else if (r < -32768) return {1'b1, 16'h8000};
    v = r[15:0];
    return {1'b0, v};
  endfunction

  // One clock: apply inputs, advance the model with the same handshake rules.
  task automatic tick(input logic v, input logic [31:0] d, input logic l, input logic tr);
    logic [16:0] sc;
    logic m_push, m_pop;
    ent_t e;
    valid_in        = v;
    data_in         = d;
    last_in         = l;
    m00_axis_tready = tr;
    m_push = v && (mq.size() < 2) && !rst_in;
    m_pop  = (mq.size() > 0) && tr;
    sc = model_scale(d);
    @(posedge clk);
    if (rst_in) begin
      mq.delete();
      m_frames = '0;
      m_sat    = '0;
    end else begin
      if (m_pop) begin
        e = mq.pop_front();
        if (e.last) m_frames = m_frames + 16'd1;
      end
      if (m_push) begin
        e.data = sc[15:0];
        e.last = l;
        mq.push_back(e);
        if (sc[16] && m_sat != 16'hFFFF) m_sat = m_sat + 16'd1;
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_in = 1'b1;
    tick(1'b1, 32'h1234_5678, 1'b1, 1'b1);
    tick(1'b0, 32'h0, 1'b0, 1'b0);
    checks++;
    if (m00_axis_tvalid !== 1'b0 || m00_axis_tdata !== 16'h0 || m00_axis_tlast !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs: got valid=%b data=%h last=%b, want 0 0000 0",
               m00_axis_tvalid, m00_axis_tdata, m00_axis_tlast);
    end
    checks++;
    if (frame_count_out !== 16'h0 || sat_count_out !== 16'h0 || ready_out !== 1'b0) begin
      failures++;
      $display("FAIL reset_status: got frames=%h sat=%h ready=%b, want 0000 0000 0",
               frame_count_out, sat_count_out, ready_out);
    end
    rst_in = 1'b0;
    #1;
    checks++;
    if (ready_out !== 1'b1) begin
      failures++;
      $display("FAIL reset_release_ready: got %b want 1", ready_out);
    end
  endtask

  task automatic test_single();
    tick(1'b1, 32'h0001_2345, 1'b1, 1'b1);
    checks++;
    if (m00_axis_tvalid !== 1'b1 || m00_axis_tdata !== 16'h0123 || m00_axis_tlast !== 1'b1) begin
      failures++;
      $display("FAIL single_out: got valid=%b data=%h last=%b, want 1 0123 1",
               m00_axis_tvalid, m00_axis_tdata, m00_axis_tlast);
    end
    tick(1'b0, 32'h0, 1'b0, 1'b1);
    checks++;
    if (m00_axis_tvalid !== 1'b0 || frame_count_out !== 16'd1) begin
      failures++;
      $display("FAIL single_after_pop: got valid=%b frames=%0d, want 0 1",
               m00_axis_tvalid, frame_count_out);
    end
  endtask

  task automatic test_saturation();
    logic [31:0] din[3];
    logic [15:0] want[3];
    din[0] = 32'h7FFF_0000; want[0] = 16'h7FFF;
    din[1] = 32'h8000_0000; want[1] = 16'h8000;
    din[2] = 32'hFFFF_FF00; want[2] = 16'hFFFF;
    for (int i = 0; i < 3; i++) begin
      tick(1'b1, din[i], 1'b0, 1'b1);
      checks++;
      if (m00_axis_tvalid !== 1'b1 || m00_axis_tdata !== want[i]) begin
        failures++;
        $display("FAIL sat_data_%0d: got valid=%b data=%h, want 1 %h",
                 i, m00_axis_tvalid, m00_axis_tdata, want[i]);
      end
    end
    checks++;
    if (sat_count_out !== 16'd2) begin
      failures++;
      $display("FAIL sat_count: got %0d want 2", sat_count_out);
    end
    tick(1'b0, 32'h0, 1'b0, 1'b1);
  endtask

  task automatic test_backpressure();
    logic [15:0] seen[$];
    tick(1'b1, 32'h0001_0000, 1'b0, 1'b0);
    checks++;
    if (ready_out !== 1'b1 || m00_axis_tdata !== 16'h0100) begin
      failures++;
      $display("FAIL bp_first: got ready=%b data=%h, want 1 0100", ready_out, m00_axis_tdata);
    end
    tick(1'b1, 32'h0002_0000, 1'b0, 1'b0);
    checks++;
    if (ready_out !== 1'b0) begin
      failures++;
      $display("FAIL bp_full_ready: got %b want 0", ready_out);
    end
    for (int i = 0; i < 3; i++) begin
      tick(1'b1, 32'h0003_0000, 1'b1, 1'b0);
      checks++;
      if (ready_out !== 1'b0 || m00_axis_tdata !== 16'h0100 || m00_axis_tvalid !== 1'b1) begin
        failures++;
        $display("FAIL bp_hold_%0d: got ready=%b valid=%b data=%h, want 0 1 0100",
                 i, ready_out, m00_axis_tvalid, m00_axis_tdata);
      end
    end
    // Release: C stays presented until the model says it was accepted.
    seen.push_back(m00_axis_tdata);
    for (int i = 0; i < 6 && m00_axis_tvalid; i++) begin
      tick(!(mq.size() == 1 && mq[0].data == 16'h0300), 32'h0003_0000, 1'b1, 1'b1);
      if (m00_axis_tvalid) seen.push_back(m00_axis_tdata);
    end
    checks++;
    if (seen.size() != 3 || seen[0] !== 16'h0100 || seen[1] !== 16'h0200 || seen[2] !== 16'h0300) begin
      failures++;
      $display("FAIL bp_order: got %0d samples first=%h, want 3 samples 0100 0200 0300",
               seen.size(), seen.size() > 0 ? seen[0] : 16'hxxxx);
    end
    checks++;
    if (m00_axis_tvalid !== 1'b0 || frame_count_out !== m_frames) begin
      failures++;
      $display("FAIL bp_drain: got valid=%b frames=%0d, want 0 %0d",
               m00_axis_tvalid, frame_count_out, m_frames);
    end
  endtask

  task automatic test_streaming();
    logic [31:0] d;
    logic [16:0] sc;
    int bad = 0;
    logic [15:0] start_frames;
    start_frames = frame_count_out;
    for (int i = 1; i <= 100; i++) begin
      d = $urandom();
      sc = model_scale(d);
      tick(1'b1, d, (i == 100), 1'b1);
      if (m00_axis_tvalid !== 1'b1 || ready_out !== 1'b1 || m00_axis_tdata !== sc[15:0]
          || m00_axis_tlast !== (i == 100)) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL stream_samples: got %0d bad cycles want 0", bad);
    end
    tick(1'b0, 32'h0, 1'b0, 1'b1);
    checks++;
    if (m00_axis_tvalid !== 1'b0 || frame_count_out !== start_frames + 16'd1
        || sat_count_out !== m_sat) begin
      failures++;
      $display("FAIL stream_end: got valid=%b frames=%0d sat=%0d, want 0 %0d %0d",
               m00_axis_tvalid, frame_count_out, sat_count_out, start_frames + 16'd1, m_sat);
    end
  endtask

  task automatic test_random();
    int bad = 0;
    for (int i = 0; i < 400; i++) begin
      tick(1'($urandom_range(0, 1)), $urandom(), 1'($urandom_range(0, 3) == 0),
           1'($urandom_range(0, 2) != 0));
      if (m00_axis_tvalid !== (mq.size() > 0) || ready_out !== (mq.size() < 2)) bad++;
      else if (mq.size() > 0 && (m00_axis_tdata !== mq[0].data || m00_axis_tlast !== mq[0].last)) bad++;
      if (frame_count_out !== m_frames || sat_count_out !== m_sat) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL random_traffic: got %0d mismatching cycles want 0", bad);
    end
  endtask

  task automatic test_reset_full();
    int stale = 0;
    tick(1'b0, 32'h0, 1'b0, 1'b1);
    tick(1'b0, 32'h0, 1'b0, 1'b1);
    tick(1'b1, 32'h0011_0000, 1'b1, 1'b0);
    tick(1'b1, 32'h0022_0000, 1'b1, 1'b0);
    checks++;
    if (ready_out !== 1'b0 || m00_axis_tvalid !== 1'b1) begin
      failures++;
      $display("FAIL rstfull_setup: got ready=%b valid=%b, want 0 1", ready_out, m00_axis_tvalid);
    end
    rst_in = 1'b1;
    tick(1'b1, 32'h0033_0000, 1'b1, 1'b1);
    rst_in = 1'b0;
    #1;
    checks++;
    if (m00_axis_tvalid !== 1'b0 || frame_count_out !== 16'h0 || sat_count_out !== 16'h0
        || ready_out !== 1'b1) begin
      failures++;
      $display("FAIL rstfull_after: got valid=%b frames=%0d sat=%0d ready=%b, want 0 0 0 1",
               m00_axis_tvalid, frame_count_out, sat_count_out, ready_out);
    end
    for (int i = 0; i < 4; i++) begin
      tick(1'b0, 32'h0, 1'b0, 1'b1);
      if (m00_axis_tvalid !== 1'b0) stale++;
    end
    checks++;
    if (stale != 0 || frame_count_out !== 16'h0) begin
      failures++;
      $display("FAIL rstfull_stale: got %0d stale cycles frames=%0d, want 0 0", stale, frame_count_out);
    end
  endtask

  task automatic test_wrap();
    rst_in = 1'b1;
    tick(1'b0, 32'h0, 1'b0, 1'b0);
    rst_in = 1'b0;
    for (int i = 0; i < 65536; i++) tick(1'b1, 32'h7FFF_0000, 1'b1, 1'b1);
    checks++;
    if (frame_count_out !== 16'hFFFF || sat_count_out !== 16'hFFFF) begin
      failures++;
      $display("FAIL wrap_top: got frames=%h sat=%h, want ffff ffff", frame_count_out, sat_count_out);
    end
    tick(1'b0, 32'h0, 1'b0, 1'b1);
    checks++;
    if (frame_count_out !== 16'h0000 || sat_count_out !== 16'hFFFF || m00_axis_tvalid !== 1'b0) begin
      failures++;
      $display("FAIL wrap_zero: got frames=%h sat=%h valid=%b, want 0000 ffff 0",
               frame_count_out, sat_count_out, m00_axis_tvalid);
    end
  endtask

  initial begin
    rst_in          = 1'b1;
    valid_in        = 1'b0;
    data_in         = '0;
    last_in         = 1'b0;
    m00_axis_tready = 1'b0;
    @(negedge clk);
    test_reset();
    test_single();
    test_saturation();
    test_backpressure();
    test_streaming();
    test_random();
    test_reset_full();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
